cc1200_access_ctrl: RTL and testbench

//  Sequences the CC1200 SPI byte engine: turns one register-access request into a CS_n framed byte stream.

---
 rtl/cc1200_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cc1200_access_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc1200_access_ctrl.sv
// CC1200 SPI access sequencer: turns one register request into a CS_n framed byte stream.
// Optional build macro CC1200_EXT_ADDR_EN enables extended-space addressing (req_addr[15:8]==8'h2F).
module cc1200_access_ctrl #(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_write,
    input  logic [15:0]      i_req_addr,
    input  logic [LEN_W-1:0] i_req_len,
    input  logic [7:0]       i_wr_data,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [7:0]       o_rd_data,
    output logic             o_rd_valid,
    output logic [7:0]       o_status_byte,
    output logic             o_done,
    output logic [1:0]       o_err,
    output logic             o_spi_start,
    output logic             o_spi_stop,
    output logic [7:0]       o_spi_data_out,
    input  logic [7:0]       i_spi_data_in,
    input  logic             i_spi_load_next,
    input  logic             i_spi_busy
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // START | spi_start pulse, header byte presented
    // EXT   | header shifting, ext register address launched next
    // DATA  | one data byte launched per engine byte boundary
    // DRAIN | last byte shifting, wait for frame end
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
`ifdef CC1200_EXT_ADDR_EN
        S_EXT,
`endif
        S_DATA,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int                CNT_W     = LEN_W + 1;
    localparam int                TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_RELOAD = TO_W'(TIMEOUT_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_write;
    logic [7:0]         r_hdr;
    logic [LEN_W-1:0]   r_len_cnt;
    logic [LEN_W-1:0]   r_fetch_cnt;
    logic [7:0]         r_hold;
    logic               r_hold_full;
    logic [CNT_W-1:0]   r_cmp;
    logic [CNT_W-1:0]   r_total;
    logic               r_samp_stat;
    logic               r_samp_data;
    logic [7:0]         r_status;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;
    logic [1:0]         r_err;
    logic               r_stop;
    logic [TO_W-1:0]    r_to_cnt;

    logic               w_ext;
    logic               w_ext_in;
    logic               w_accept;
    logic               w_active;
    logic               w_wait;
    logic               w_wr_hs;
    logic               w_to_hit;
    logic               w_stop_set;
    logic               w_data_launch;
    logic               w_use_hold;
    logic               w_bypass;
    logic               w_underrun;
    logic [7:0]         w_byte;
    logic [5:0]         w_hdr_addr;

`ifdef CC1200_EXT_ADDR_EN
    logic               r_ext;
    logic [7:0]         r_addr_lo;
    assign w_ext      = r_ext;
    assign w_ext_in   = (i_req_addr[15:8] == 8'h2F);
    assign w_hdr_addr = w_ext_in ? 6'h2F : i_req_addr[5:0];
    assign w_wait     = (r_state == S_EXT) || (r_state == S_DATA) || (r_state == S_DRAIN);
`else
    logic [9:0]         w_unused_addr;
    assign w_unused_addr = i_req_addr[15:6];
    assign w_ext         = 1'b0;
    assign w_ext_in      = 1'b0;
    assign w_hdr_addr    = i_req_addr[5:0];
    assign w_wait        = (r_state == S_DATA) || (r_state == S_DRAIN);
`endif

    assign w_accept    = i_req_valid && (r_state == S_IDLE);
    assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_req_ready = (r_state == S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_wr_ready  = r_write && (r_fetch_cnt != '0) && !r_hold_full &&
                         w_active && (r_state != S_DRAIN);
    assign w_wr_hs     = i_wr_valid && o_wr_ready;
    assign w_to_hit    = w_wait && (r_to_cnt == '0) && !i_spi_load_next;

    assign o_spi_stop    = r_stop || w_stop_set;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_status_byte = r_status;
    assign o_err         = r_err;

    always_comb begin
        w_next         = r_state;
        o_spi_start    = 1'b0;
        o_spi_data_out = 8'h00;
        w_stop_set     = 1'b0;
        w_data_launch  = 1'b0;
        w_use_hold     = 1'b0;
        w_bypass       = 1'b0;
        w_underrun     = 1'b0;
        w_byte         = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_START;
            end
            S_START: begin
                o_spi_start    = 1'b1;
                o_spi_data_out = r_hdr;
                if (w_ext) begin
`ifdef CC1200_EXT_ADDR_EN
                    w_next = S_EXT;
`endif
                end else if (r_len_cnt != '0) begin
                    w_next = S_DATA;
                end else begin
                    w_stop_set = 1'b1;
                    w_next     = S_DRAIN;
                end
            end
`ifdef CC1200_EXT_ADDR_EN
            S_EXT: begin
                if (i_spi_load_next) begin
                    o_spi_data_out = r_addr_lo;
                    if (r_len_cnt == '0) begin
                        w_stop_set = 1'b1;
                        w_next     = S_DRAIN;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
`endif
            S_DATA: begin
                if (i_spi_load_next) begin
                    w_data_launch = 1'b1;
                    if (r_write) begin
                        // holding reg first, then a same-cycle stream byte, else underrun filler
                        if (r_hold_full) begin
                            w_byte     = r_hold;
                            w_use_hold = 1'b1;
                        end else if (w_wr_hs) begin
                            w_byte   = i_wr_data;
                            w_bypass = 1'b1;
                        end else begin
                            w_underrun = 1'b1;
                        end
                    end
                    o_spi_data_out = w_byte;
                    if (r_len_cnt == LEN_W'(1)) begin
                        w_stop_set = 1'b1;
                        w_next     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!i_spi_busy && (r_cmp == r_total) && !r_samp_stat && !r_samp_data)
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_to_hit) begin
            w_stop_set = 1'b1;
            w_next     = S_DONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_hdr       <= 8'h00;
            r_len_cnt   <= '0;
            r_fetch_cnt <= '0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_cmp       <= '0;
            r_total     <= '0;
            r_samp_stat <= 1'b0;
            r_samp_data <= 1'b0;
            r_status    <= 8'h00;
            r_rd_data   <= 8'h00;
            r_rd_valid  <= 1'b0;
            r_err       <= 2'b00;
            r_stop      <= 1'b0;
            r_to_cnt    <= TO_RELOAD;
`ifdef CC1200_EXT_ADDR_EN
            r_ext       <= 1'b0;
            r_addr_lo   <= 8'h00;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write     <= i_req_write;
                r_hdr       <= {~i_req_write, (i_req_len > LEN_W'(1)), w_hdr_addr};
                r_len_cnt   <= i_req_len;
                r_fetch_cnt <= i_req_write ? i_req_len : '0;
                r_hold_full <= 1'b0;
                r_cmp       <= '0;
                r_total     <= CNT_W'(i_req_len) + CNT_W'(w_ext_in) + CNT_W'(1);
                r_err       <= 2'b00;
                r_stop      <= 1'b0;
`ifdef CC1200_EXT_ADDR_EN
                r_ext       <= w_ext_in;
                r_addr_lo   <= i_req_addr[7:0];
`endif
            end else begin
                if (i_spi_load_next && w_active) r_cmp <= r_cmp + CNT_W'(1);
                if (w_data_launch) r_len_cnt <= r_len_cnt - LEN_W'(1);
                if (w_wr_hs || w_underrun) r_fetch_cnt <= r_fetch_cnt - LEN_W'(1);
                if (w_use_hold) begin
                    r_hold_full <= 1'b0;
                end else if (w_wr_hs && !w_bypass) begin
                    r_hold      <= i_wr_data;
                    r_hold_full <= 1'b1;
                end
                if (w_underrun) r_err[0] <= 1'b1;
                if (w_to_hit)   r_err[1] <= 1'b1;
                if (w_next == S_IDLE)  r_stop <= 1'b0;
                else if (w_stop_set)   r_stop <= 1'b1;
            end
            // completed byte index decides whether the next-cycle sample is status, ext echo or data
            r_samp_stat <= i_spi_load_next && w_active && (r_cmp == '0);
            r_samp_data <= i_spi_load_next && w_active && !r_write && (r_cmp > CNT_W'(w_ext));
            if (r_samp_stat) r_status <= i_spi_data_in;
            if (r_samp_data) r_rd_data <= i_spi_data_in;
            r_rd_valid <= r_samp_data;
            if (!w_wait || i_spi_load_next || (w_next != r_state))
                r_to_cnt <= TO_RELOAD;
            else if (r_to_cnt != '0)
                r_to_cnt <= r_to_cnt - TO_W'(1);
        end
    end

endmodule

// File: tb/tb_cc1200_access_ctrl.sv
// Directed bench for cc1200_access_ctrl with a behavioural SPI byte-engine model.
module tb_cc1200_access_ctrl;
    localparam int LEN_W = 8;
    localparam int TO    = 100;

    logic             clk;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [15:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [7:0]       status_byte;
    logic             done;
    logic [1:0]       err;
    logic             spi_start;
    logic             spi_stop;
    logic [7:0]       spi_data_out;
    logic [7:0]       spi_data_in;
    logic             spi_load_next;
    logic             spi_busy;

    cc1200_access_ctrl #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr), .i_req_len(req_len),
        .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_status_byte(status_byte), .o_done(done), .o_err(err),
        .o_spi_start(spi_start), .o_spi_stop(spi_stop), .o_spi_data_out(spi_data_out),
        .i_spi_data_in(spi_data_in), .i_spi_load_next(spi_load_next), .i_spi_busy(spi_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // engine model: 4 cycles per byte, load_next at each byte boundary
    logic [7:0] m_miso [0:15];
    logic [7:0] m_bytes [$];
    logic       m_stops [$];
    bit         m_hang  = 0;
    bit         m_idle  = 1;
    int         m_start_cyc = 0;

    initial begin : engine
        int k;
        bit last;
        bit was;
        spi_load_next = 1'b0;
        spi_busy      = 1'b0;
        spi_data_in   = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                m_idle = 0;
                m_start_cyc = cyc;
                m_bytes.push_back(spi_data_out);
                m_stops.push_back(spi_stop);
                last = spi_stop;
                spi_busy = 1'b1;
                k = 0;
                if (m_hang) begin
                    while (m_hang) @(negedge clk);
                end else begin
                    was = 0;
                    while (!was && k < 12) begin
                        repeat (3) @(negedge clk);
                        spi_load_next = 1'b1;
                        spi_data_in   = m_miso[k];
                        k++;
                        was = last;
                        #1;
                        if (!was) begin
                            m_bytes.push_back(spi_data_out);
                            m_stops.push_back(spi_stop);
                            last = spi_stop;
                        end
                        @(negedge clk);
                        spi_load_next = 1'b0;
                    end
                end
                spi_busy = 1'b0;
                m_idle = 1;
            end
        end
    end

    logic [7:0] rd_q [$];
    int  done_cnt = 0;
    int  done_cyc = 0;
    bit  ready_at_done = 0;
    bit  stop_at_done = 0;
    int  wr_rdy_cnt = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rd_valid) rd_q.push_back(rd_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                ready_at_done = req_ready;
                stop_at_done = spi_stop;
            end
            if (wr_ready) wr_rdy_cnt++;
        end
    end

    logic [7:0] wr_vec [0:7];
    int  wr_n   = 0;
    int  wr_idx = 0;

    initial begin : wr_driver
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (wr_idx < wr_n) begin
                wr_valid = 1'b1;
                wr_data  = wr_vec[wr_idx];
            end else begin
                wr_valid = 1'b0;
            end
            #2;
            if (wr_valid && wr_ready) wr_idx++;
        end
    end

    function automatic logic [31:0] pack4(input logic [7:0] q [$]);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i < q.size()) v[31-8*i -: 8] = q[i];
        return v;
    endfunction

    function automatic logic [7:0] pack_stops(input logic q [$]);
        logic [7:0] v = 8'h0;
        for (int i = 0; i < 8; i++)
            if (i < q.size()) v[i] = q[i];
        return v;
    endfunction

    task automatic clear_obs();
        m_bytes.delete();
        m_stops.delete();
        rd_q.delete();
        done_cnt   = 0;
        wr_rdy_cnt = 0;
        wr_idx     = 0;
    endtask

    task automatic issue(input logic w, input logic [15:0] a, input logic [LEN_W-1:0] l);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL wait_done: done not seen after %0d cycles", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_engine_idle();
        int n = 0;
        while (!m_idle && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!m_idle) begin
            bad++;
            $display("FAIL engine_idle: engine still busy after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 16'h0;
        req_len = '0;
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++;
        if ({spi_start, spi_stop, done, rd_valid, wr_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 00000", {spi_start, spi_stop, done, rd_valid, wr_ready});
        end
        total++;
        if ({err, status_byte, rd_data, spi_data_out} !== 26'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {err, status_byte, rd_data, spi_data_out});
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        clear_obs();
        wr_vec[0] = 8'hA5;
        wr_n = 1;
        issue(1'b1, 16'h0010, 8'd1);
        wait_done();
        wait_engine_idle();
        total++;
        if (m_bytes.size() != 2 || pack4(m_bytes) !== 32'h10A5_0000) begin
            bad++; $display("FAIL wr1_bytes: got n=%0d %h want n=2 10a50000", m_bytes.size(), pack4(m_bytes));
        end
        total++;
        if (pack_stops(m_stops) !== 8'h02) begin bad++; $display("FAIL wr1_stop: got %h want 02", pack_stops(m_stops)); end
        total++;
        if (done_cnt != 1 || err !== 2'b00) begin
            bad++; $display("FAIL wr1_done_err: got done=%0d err=%b want 1 00", done_cnt, err);
        end
        total++;
        if (wr_idx != 1 || rd_q.size() != 0) begin
            bad++; $display("FAIL wr1_stream: got wr=%0d rd=%0d want 1 0", wr_idx, rd_q.size());
        end
        wr_n = 0;
    endtask

    task automatic test_burst_read();
        clear_obs();
        m_miso[0] = 8'h0F; m_miso[1] = 8'h01; m_miso[2] = 8'h02; m_miso[3] = 8'h03; m_miso[4] = 8'h04;
        issue(1'b0, 16'h0000, 8'd4);
        wait_done();
        wait_engine_idle();
        total++;
        if (m_bytes.size() != 5 || pack4(m_bytes) !== 32'hC000_0000 || m_bytes[4] !== 8'h00) begin
            bad++; $display("FAIL rd4_bytes: got n=%0d %h want n=5 c0000000", m_bytes.size(), pack4(m_bytes));
        end
        total++;
        if (pack_stops(m_stops) !== 8'h10) begin bad++; $display("FAIL rd4_stop: got %h want 10", pack_stops(m_stops)); end
        total++;
        if (status_byte !== 8'h0F) begin bad++; $display("FAIL rd4_status: got %h want 0f", status_byte); end
        total++;
        if (rd_q.size() != 4 || pack4(rd_q) !== 32'h0102_0304) begin
            bad++; $display("FAIL rd4_data: got n=%0d %h want n=4 01020304", rd_q.size(), pack4(rd_q));
        end
        total++;
        if (done_cnt != 1 || err !== 2'b00) begin
            bad++; $display("FAIL rd4_done_err: got done=%0d err=%b want 1 00", done_cnt, err);
        end
    endtask

    task automatic test_strobe();
        clear_obs();
        m_miso[0] = 8'h5A;
        issue(1'b1, 16'h0036, 8'd0);
        wait_done();
        wait_engine_idle();
        total++;
        if (m_bytes.size() != 1 || pack4(m_bytes) !== 32'h3600_0000) begin
            bad++; $display("FAIL strobe_bytes: got n=%0d %h want n=1 36000000", m_bytes.size(), pack4(m_bytes));
        end
        total++;
        if (pack_stops(m_stops) !== 8'h01) begin bad++; $display("FAIL strobe_stop: got %h want 01", pack_stops(m_stops)); end
        total++;
        if (status_byte !== 8'h5A) begin bad++; $display("FAIL strobe_status: got %h want 5a", status_byte); end
        total++;
        if (rd_q.size() != 0 || wr_rdy_cnt != 0 || done_cnt != 1) begin
            bad++; $display("FAIL strobe_side: got rd=%0d wr_ready=%0d done=%0d want 0 0 1", rd_q.size(), wr_rdy_cnt, done_cnt);
        end
    endtask

    task automatic test_ext();
        clear_obs();
        m_miso[0] = 8'h3C; m_miso[1] = 8'h77; m_miso[2] = 8'h99;
        issue(1'b0, 16'h2F8F, 8'd1);
        wait_done();
        wait_engine_idle();
`ifdef CC1200_EXT_ADDR_EN
        total++;
        if (m_bytes.size() != 3 || pack4(m_bytes) !== 32'hAF8F_0000) begin
            bad++; $display("FAIL ext_bytes: got n=%0d %h want n=3 af8f0000", m_bytes.size(), pack4(m_bytes));
        end
        total++;
        if (pack_stops(m_stops) !== 8'h04) begin bad++; $display("FAIL ext_stop: got %h want 04", pack_stops(m_stops)); end
        total++;
        if (rd_q.size() != 1 || rd_q[0] !== 8'h99) begin
            bad++; $display("FAIL ext_rd: got n=%0d %h want n=1 99", rd_q.size(), pack4(rd_q));
        end
`else
        total++;
        if (m_bytes.size() != 2 || pack4(m_bytes) !== 32'h8F00_0000) begin
            bad++; $display("FAIL ext_bytes: got n=%0d %h want n=2 8f000000", m_bytes.size(), pack4(m_bytes));
        end
        total++;
        if (pack_stops(m_stops) !== 8'h02) begin bad++; $display("FAIL ext_stop: got %h want 02", pack_stops(m_stops)); end
        total++;
        if (rd_q.size() != 1 || rd_q[0] !== 8'h77) begin
            bad++; $display("FAIL ext_rd: got n=%0d %h want n=1 77", rd_q.size(), pack4(rd_q));
        end
`endif
        total++;
        if (status_byte !== 8'h3C) begin bad++; $display("FAIL ext_status: got %h want 3c", status_byte); end
    endtask

    task automatic test_underrun();
        clear_obs();
        wr_vec[0] = 8'h11; wr_vec[1] = 8'h22;
        wr_n = 2;
        issue(1'b1, 16'h000A, 8'd3);
        wait_done();
        wait_engine_idle();
        total++;
        if (m_bytes.size() != 4 || pack4(m_bytes) !== 32'h4A11_2200) begin
            bad++; $display("FAIL undr_bytes: got n=%0d %h want n=4 4a112200", m_bytes.size(), pack4(m_bytes));
        end
        total++;
        if (pack_stops(m_stops) !== 8'h08) begin bad++; $display("FAIL undr_stop: got %h want 08", pack_stops(m_stops)); end
        total++;
        if (err !== 2'b01 || done_cnt != 1) begin
            bad++; $display("FAIL undr_err: got err=%b done=%0d want 01 1", err, done_cnt);
        end
        wr_n = 0;
    endtask

    task automatic test_timeout();
        clear_obs();
        m_hang = 1;
        issue(1'b0, 16'h0005, 8'd2);
        wait_done();
        total++;
        if (err !== 2'b10) begin bad++; $display("FAIL to_err: got %b want 10", err); end
        total++;
        if (done_cyc - m_start_cyc != TO + 1) begin
            bad++; $display("FAIL to_cycles: got %0d want %0d", done_cyc - m_start_cyc, TO + 1);
        end
        total++;
        if (stop_at_done !== 1'b1 || done_cnt != 1) begin
            bad++; $display("FAIL to_stop: got stop=%b done=%0d want 1 1", stop_at_done, done_cnt);
        end
        m_hang = 0;
        wait_engine_idle();
    endtask

    task automatic test_back_to_back();
        clear_obs();
        wr_vec[0] = 8'h3C;
        wr_n = 1;
        issue(1'b1, 16'h0001, 8'd1);
        wait_done();
        total++;
        if (err !== 2'b00) begin bad++; $display("FAIL b2b_err_clear: got %b want 00", err); end
        total++;
        if (ready_at_done !== 1'b0) begin bad++; $display("FAIL b2b_ready_at_done: got %b want 0", ready_at_done); end
        wait_engine_idle();
        clear_obs();
        wr_vec[0] = 8'hC3;
        wr_n = 1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0002;
        req_len   = 8'd1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();
        wait_engine_idle();
        total++;
        if (m_bytes.size() != 2 || pack4(m_bytes) !== 32'h02C3_0000) begin
            bad++; $display("FAIL b2b_bytes: got n=%0d %h want n=2 02c30000", m_bytes.size(), pack4(m_bytes));
        end
        wr_n = 0;
    endtask

    task automatic test_reset_mid();
        clear_obs();
        for (int i = 0; i < 12; i++) m_miso[i] = 8'hE0 + 8'(i);
        issue(1'b0, 16'h0003, 8'd8);
        repeat (14) @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if ({req_ready, spi_start, spi_stop, done, rd_valid, wr_ready} !== 6'b100000) begin
            bad++; $display("FAIL rstmid_ctl: got %b want 100000", {req_ready, spi_start, spi_stop, done, rd_valid, wr_ready});
        end
        total++;
        if ({err, status_byte, rd_data, spi_data_out} !== 26'h0) begin
            bad++; $display("FAIL rstmid_data: got %h want 0", {err, status_byte, rd_data, spi_data_out});
        end
        @(negedge clk);
        rstn = 1'b1;
        wait_engine_idle();
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL rstmid_done: got %0d want 0", done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_miso[i] = 8'h00;
        test_reset();
        test_single_write();
        test_burst_read();
        test_strobe();
        test_ext();
        test_underrun();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_single_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
